// File: rtl/cordic_out_stage.sv
// ============================================================================
// Module   : cordic_out_stage
// Purpose  : CORDIC output stage. Aligns valid/flip with the rotation pipeline,
//            applies quadrant negation, registers sin/cos. Optional saturation
//            and overflow counting enabled by macro CORDIC_OUT_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_out_stage #(
    parameter int W      = 12,
    parameter int STAGES = 12,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                in_valid,
    input  logic                in_flip,
    input  logic signed [W-1:0] sin_in,
    input  logic signed [W-1:0] cos_in,
    input  logic                ovf_clr,
    output logic signed [W-1:0] sin_out,
    output logic signed [W-1:0] cos_out,
    output logic                out_valid,
    output logic                ovf,
    output logic [CNT_W-1:0]    ovf_cnt
);

    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

    logic [STAGES-1:0]   vld_dly;
    logic [STAGES-1:0]   flp_dly;
    logic                tail_v;
    logic                tail_f;
    logic signed [W-1:0] sin_cor;
    logic signed [W-1:0] cos_cor;

    // Bit 0 is the newest entry; bit STAGES-1 lines up with sin_in/cos_in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_dly <= '0;
            flp_dly <= '0;
        end else if (ce) begin
            vld_dly <= (vld_dly << 1) | STAGES'(in_valid);
            flp_dly <= (flp_dly << 1) | STAGES'(in_flip);
        end
    end

    assign tail_v = vld_dly[STAGES-1];
    assign tail_f = flp_dly[STAGES-1];

`ifdef CORDIC_OUT_SAT_EN
    logic ovf_event;

    always_comb begin
        sin_cor = sin_in;
        cos_cor = cos_in;
        if (tail_f) begin
            sin_cor = (sin_in == MIN_VAL) ? MAX_VAL : -sin_in;
            cos_cor = (cos_in == MIN_VAL) ? MAX_VAL : -cos_in;
        end
    end

    // Either channel saturating counts as a single event.
    assign ovf_event = tail_v & tail_f & ((sin_in == MIN_VAL) | (cos_in == MIN_VAL));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            ovf <= ce & ovf_event;
            if (ce) begin
                if (ovf_clr)
                    ovf_cnt <= ovf_event ? CNT_W'(1) : '0;
                else if (ovf_event && (ovf_cnt != {CNT_W{1'b1}}))
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_ovf_clr;

    always_comb begin
        sin_cor = sin_in;
        cos_cor = cos_in;
        if (tail_f) begin
            sin_cor = -sin_in;
            cos_cor = -cos_in;
        end
    end

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
    assign ovf_cnt        = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            sin_out   <= sin_cor;
            cos_out   <= cos_cor;
            out_valid <= tail_v;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cordic_out_stage.sv
// ============================================================================
// Module   : tb_cordic_out_stage
// Purpose  : Self-checking bench for cordic_out_stage (vector table, directed
//            corner sequences, randomized run against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_out_stage;

    localparam int W      = 12;
    localparam int STAGES = 12;
    localparam int CNT_W  = 16;
`ifdef CORDIC_OUT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int SATV = SAT ? 2047 : -2048;

    logic                clock = 1'b0;
    logic                reset_n = 1'b1;
    logic                ce = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_flip = 1'b0;
    logic                ovf_clr = 1'b0;
    logic signed [W-1:0] sin_in = '0;
    logic signed [W-1:0] cos_in = '0;
    logic signed [W-1:0] sin_out;
    logic signed [W-1:0] cos_out;
    logic                out_valid;
    logic                ovf;
    logic [CNT_W-1:0]    ovf_cnt;

    logic                v4 = 1'b0;
    logic                f4 = 1'b0;
    logic                clr4 = 1'b0;
    logic signed [W-1:0] s4 = '0;
    logic signed [W-1:0] c4 = '0;
    logic signed [W-1:0] so4;
    logic signed [W-1:0] co4;
    logic                ov4;
    logic                ovf4;
    logic [3:0]          cnt4;

    cordic_out_stage #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_flip(in_flip), .sin_in(sin_in), .cos_in(cos_in), .ovf_clr(ovf_clr),
        .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid),
        .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    cordic_out_stage #(.W(W), .STAGES(2), .CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .ce(ce), .in_valid(v4),
        .in_flip(f4), .sin_in(s4), .cos_in(c4), .ovf_clr(clr4),
        .sin_out(so4), .cos_out(co4), .out_valid(ov4),
        .ovf(ovf4), .ovf_cnt(cnt4)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of the last STAGES {valid,flip} entries.
    bit mv[$];
    bit mf[$];
    int e_sin, e_cos, e_cnt;
    bit e_valid, e_ovf;

    function automatic int negw(input int x);
        int v;
        v = -x;
        if (v > 2047) v = SAT ? 2047 : -2048;
        return v;
    endfunction

    task automatic model_reset();
        mv.delete();
        mf.delete();
        for (int i = 0; i < STAGES; i++) begin
            mv.push_back(1'b0);
            mf.push_back(1'b0);
        end
        e_sin = 0; e_cos = 0; e_cnt = 0; e_valid = 0; e_ovf = 0;
    endtask

    task automatic model_step();
        bit tv, tf, ev;
        if (!reset_n) return;
        if (!ce) begin
            e_ovf = 1'b0;
            return;
        end
        tv = mv.pop_front();
        tf = mf.pop_front();
        mv.push_back(in_valid);
        mf.push_back(in_flip);
        e_sin   = tf ? negw(int'(sin_in)) : int'(sin_in);
        e_cos   = tf ? negw(int'(cos_in)) : int'(cos_in);
        e_valid = tv;
        ev = SAT && tv && tf && (int'(sin_in) == -2048 || int'(cos_in) == -2048);
        e_ovf = ev;
        if (SAT && ovf_clr) e_cnt = ev ? 1 : 0;
        else if (ev && e_cnt < 65535) e_cnt++;
    endtask

    task automatic tick();
        model_step();
        @(negedge clock);
    endtask

    task automatic check_model();
        chk("m_sin",   sin_out,   e_sin);
        chk("m_cos",   cos_out,   e_cos);
        chk("m_valid", out_valid, e_valid);
        chk("m_ovf",   ovf,       e_ovf);
        chk("m_cnt",   ovf_cnt,   e_cnt);
    endtask

    typedef struct {
        bit flip;
        int sin_v;
        int cos_v;
        int exp_sin;
        int exp_cos;
        bit exp_ovf;
    } vec_t;

    vec_t vt[7];

    initial begin
        int ecnt;
        logic signed [W-1:0] ps, pc;
        logic pv;

        vt[0] = '{1'b0,   724,   724,   724,   724, 1'b0};
        vt[1] = '{1'b1,   300, -1000,  -300,  1000, 1'b0};
        vt[2] = '{1'b1,     0,  2047,     0, -2047, 1'b0};
        vt[3] = '{1'b0, -2048,     5, -2048,     5, 1'b0};
        vt[4] = '{1'b1, -2048,     1,  SATV,    -1, SAT};
        vt[5] = '{1'b1,     1, -2048,    -1,  SATV, SAT};
        vt[6] = '{1'b1, -2048, -2048,  SATV,  SATV, SAT};

        #1 reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("rst_sin",   sin_out,   0);
        chk("rst_cos",   cos_out,   0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf",   ovf,       0);
        chk("rst_cnt",   ovf_cnt,   0);

        // Table-driven single samples: valid at cycle 0, data at cycle STAGES.
        ce = 1'b1;
        ecnt = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_flip = vt[i].flip; sin_in = '0; cos_in = '0;
            tick();
            in_valid = 1'b0; in_flip = 1'b0;
            repeat (STAGES - 1) tick();
            chk("early_valid", out_valid, 0);
            sin_in = W'(vt[i].sin_v);
            cos_in = W'(vt[i].cos_v);
            tick();
            if (vt[i].exp_ovf) ecnt++;
            chk("vec_valid", out_valid, 1);
            chk("vec_sin",   sin_out,   vt[i].exp_sin);
            chk("vec_cos",   cos_out,   vt[i].exp_cos);
            chk("vec_ovf",   ovf,       vt[i].exp_ovf);
            chk("vec_cnt",   ovf_cnt,   ecnt);
            sin_in = '0; cos_in = '0;
            tick();
            chk("vec_pulse_valid", out_valid, 0);
            chk("vec_pulse_ovf",   ovf,       0);
        end

        // Stall: continuous valid stream, ce pattern 1,0,0,1,...
        for (int i = 0; i < 48; i++) begin
            ce       = (i % 4 == 0) || (i % 4 == 3);
            in_valid = 1'b1;
            in_flip  = 1'($urandom);
            sin_in   = (i % 5 == 0) ? W'(-2048) : W'($urandom);
            cos_in   = W'($urandom);
            ps = sin_out; pc = cos_out; pv = out_valid;
            tick();
            check_model();
            if (!ce) begin
                chk("stall_sin",   sin_out,   ps);
                chk("stall_cos",   cos_out,   pc);
                chk("stall_valid", out_valid, pv);
                chk("stall_ovf",   ovf,       0);
            end
        end

        // Saturating counter on the 4-bit, 2-stage instance.
        ce = 1'b1; in_valid = 1'b0;
        v4 = 1'b1; f4 = 1'b1; s4 = W'(-2048); c4 = W'(10);
        repeat (25) tick();
        chk("cnt4_hold", cnt4, SAT ? 15 : 0);
        chk("cnt4_sin",  so4,  SATV);
        chk("cnt4_ovf",  ovf4, SAT);
        clr4 = 1'b1;
        tick();
        chk("cnt4_clr_ev", cnt4, SAT ? 1 : 0);
        clr4 = 1'b0; v4 = 1'b0;
        repeat (4) tick();
        chk("cnt4_drain", cnt4, SAT ? 3 : 0);
        chk("cnt4_ovf0",  ovf4, 0);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("cnt4_clr", cnt4, 0);

        // Asynchronous reset with samples in flight.
        in_valid = 1'b1; in_flip = 1'b0; sin_in = W'(100); cos_in = W'(-100);
        repeat (5) tick();
        chk("pre_rst_sin", sin_out, 100);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_sin",   sin_out,   0);
        chk("arst_cos",   cos_out,   0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ovf",   ovf,       0);
        chk("arst_cnt",   ovf_cnt,   0);
        in_valid = 1'b0;
        @(negedge clock);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_valid", out_valid, 0);
        end

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            ce       = ($urandom % 4) != 0;
            in_valid = 1'($urandom);
            in_flip  = 1'($urandom);
            sin_in   = ($urandom % 6 == 0) ? W'(-2048) : W'($urandom);
            cos_in   = ($urandom % 6 == 0) ? W'(-2048) : W'($urandom);
            ovf_clr  = ($urandom % 16) == 0;
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cordic_out_stage.md
# cordic_out_stage

Output stage of the pipelined CORDIC sin/cos processor, sitting directly downstream of the last `cordic_step` stage. It carries each sample's valid flag and quadrant-flip flag alongside the rotation pipeline, so they arrive aligned with the final sin/cos values. It applies the quadrant correction (negation for angles folded by ±π), optionally saturates, and registers the corrected result with a matching valid strobe. It also keeps an overflow event counter for diagnostics.

## Interface
- `W`, 12: data width, signed fixed point Fixpoint(12:10), so 1.0 = 1024.
- `STAGES`, 12: number of `cordic_step` register stages between pipeline entry and `sin_in`/`cos_in`; must be ≥1.
- `CNT_W`, 16: overflow counter width.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable, shared with the CORDIC step stages.
- `in_valid`  in  1  sample valid at pipeline entry (same cycle the angle enters stage 0).
- `in_flip`  in  1  quadrant flag at pipeline entry: 1 means the target angle was folded by ±π, so results must be negated.
- `sin_in`  in  W  signed sine from last step.
- `cos_in`  in  W  signed cosine from last step.
- `ovf_clr`  in  1  synchronous clear of `ovf_cnt` (qualified by `ce`).
- `sin_out`  out  W  corrected sine, registered.
- `cos_out`  out  W  corrected cosine, registered.
- `out_valid`  out  1  `sin_out`/`cos_out` hold a valid sample.
- `ovf`  out  1  one-cycle pulse: a valid sample was saturated this update.
- `ovf_cnt`  out  CNT_W  saturating count of saturated valid samples.

## Operation
- Delay line: `STAGES` entries of {valid, flip}, shifted in from `in_valid`/`in_flip` on every clock with `ce`=1. The tail entry (depth `STAGES`) is aligned with `sin_in`/`cos_in`.
- Correction, computed from the tail entry:
  - tail flip=0: pass `sin_in`/`cos_in` through unchanged.
  - tail flip=1: output `-sin_in`/`-cos_in`, negated in W bits.
- Output registers load on every `ce`=1 clock, regardless of tail valid. `out_valid` loads the tail valid.
- Negation edge case: only −2^(W−1) (−2048) has no positive W-bit counterpart. Handling depends on `CORDIC_OUT_SAT_EN` (see Configuration).
- Overflow event: tail valid=1, flip=1, and either input equal to −2^(W−1). Both channels overflowing in the same sample counts as one event.
- `ovf` is registered: `ovf <= ce & event`, so it is low on any cycle with `ce`=0.
- `ovf_cnt` update, on `ce`=1 only:
  - `ovf_clr` alone loads 0.
  - `ovf_clr` together with an event loads 1.
  - event alone increments, holding at all-ones (no wrap).
- No internal state machine beyond the delay line. The block applies no backpressure; it is a fixed-latency pipeline.

## Timing
- Latency: `in_valid` at ce-cycle n gives `out_valid` at ce-cycle n+STAGES+1.
- Data latency: `sin_in`/`cos_in` to `sin_out`/`cos_out` is 1 ce-cycle.
- `ce`=0: delay line, outputs, and counter all hold; `ovf` drops to 0.
- Reset values:
  - `sin_out`, `cos_out`: 0
  - `out_valid`: 0
  - `ovf`: 0
  - `ovf_cnt`: 0
  - all delay-line entries: {0,0}
- Reset mid-operation drops every in-flight sample. No `out_valid` appears until `STAGES`+1 ce-cycles after the first new `in_valid` following reset release.
- Back-to-back valid samples every ce-cycle are supported: throughput is 1 sample per ce-cycle.

## Configuration
- Macro: `CORDIC_OUT_SAT_EN`.
- Defined:
  - negating −2^(W−1) yields +2^(W−1)−1 (2047).
  - overflow events drive `ovf` and `ovf_cnt` as above.
- Undefined:
  - plain two's-complement negation, so −2048 stays −2048.
  - `ovf` and `ovf_cnt` are tied to 0 and no counter logic is built.
  - `ovf_clr` is ignored.

## Test plan
- Latency: reset, `ce`=1, single `in_valid`=1 with `in_flip`=0 at cycle 0, `sin_in`=724 and `cos_in`=724 presented at cycle 12 → `out_valid`=1 only at cycle 13 with `sin_out`=724 and `cos_out`=724.
- Flip: same as above but `in_flip`=1, with `sin_in`=300 and `cos_in`=−1000 at the tail → `sin_out`=−300, `cos_out`=1000.
- Stall: continuous valid stream with `ce` toggled as 1,0,0,1,… → outputs and `out_valid` frozen during `ce`=0, no sample lost or duplicated, `ovf`=0 while `ce`=0.
- Saturation (macro on): flipped valid sample with `sin_in`=−2048 → `sin_out`=2047, `ovf` pulses once, `ovf_cnt`=1. Same sample with macro off → `sin_out`=−2048, `ovf_cnt`=0.
- Counter:
  - with `CNT_W`=4, apply 20 overflow samples → `ovf_cnt` holds at 15.
  - `ovf_clr` asserted in the same cycle as an event → `ovf_cnt`=1.
  - `ovf_clr` alone → `ovf_cnt`=0.
- Reset mid-stream: assert `reset_n`=0 while 5 samples are in flight → all outputs 0 immediately (asynchronous), and no stale `out_valid` after release.
